// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for an in-order pipeline: tracks EX..WB producers, raises stall/flush, selects forwarding.
// Build macro PIPE_HAZARD_FWD_EN enables forwarding and limits stalls to load-use hazards.
module pipe_hazard_ctrl #(
    parameter int STAGES     = 5,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = 3
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  hold_pc,
    output logic                  hold_if_id,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic [SEL_W-1:0]      fwd_a,
    output logic [SEL_W-1:0]      fwd_b,
    output logic [STAGES-3:0]     stage_valid,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int N = STAGES - 2;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  memRead;
    } entry_t;

    entry_t [N-1:0] entries;
    entry_t         newEntry;
    logic           hitA;
    logic           hitB;
    logic           stallRaw;
    logic           stall;
    logic           branch;
    logic           issue;

    // Register 0 is hardwired, so it never counts as a produced value.
    function automatic logic producerMatch(input entry_t e, input logic [REG_ADDR_W-1:0] src);
        return e.valid && e.regWrite && (e.rd == src) && (src != '0);
    endfunction

`ifdef PIPE_HAZARD_FWD_EN
    logic [REG_ADDR_W-1:0] exRs;
    logic [REG_ADDR_W-1:0] exRt;
    logic                  seenA;
    logic                  seenB;

    // Only the youngest producer matters; a load stalls until it reaches stage STAGES-2.
    always_comb begin
        hitA  = 1'b0;
        hitB  = 1'b0;
        seenA = 1'b0;
        seenB = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!seenA && producerMatch(entries[i], id_rs)) begin
                seenA = 1'b1;
                hitA  = entries[i].memRead && (i <= STAGES - 5);
            end
            if (!seenB && producerMatch(entries[i], id_rt)) begin
                seenB = 1'b1;
                hitB  = entries[i].memRead && (i <= STAGES - 5);
            end
        end
    end

    // Descending scan so the smallest matching index wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int i = N - 1; i >= 1; i--) begin
            if (producerMatch(entries[i], exRs)) fwd_a = SEL_W'(i);
            if (producerMatch(entries[i], exRt)) fwd_b = SEL_W'(i);
        end
    end
`else
    logic unusedEntries;
    assign unusedEntries = ^entries;

    // Without forwarding, any producer short of WB blocks the read.
    always_comb begin
        hitA = 1'b0;
        hitB = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (producerMatch(entries[i], id_rs)) hitA = 1'b1;
            if (producerMatch(entries[i], id_rt)) hitB = 1'b1;
        end
    end

    assign fwd_a = '0;
    assign fwd_b = '0;
`endif

    // Gating with rst keeps every control output low while reset is held.
    always_comb begin
        stallRaw     = id_valid && ((id_rs_used && hitA) || (id_rt_used && hitB));
        branch       = ex_branch_taken && rst;
        stall        = stallRaw && rst && !ex_branch_taken;
        hold_pc      = stall;
        hold_if_id   = stall;
        bubble_id_ex = stall || branch;
        flush_if_id  = branch;
        issue        = id_valid && !stall && !branch;
        newEntry     = '0;
        if (issue) begin
            newEntry.valid    = 1'b1;
            newEntry.rd       = id_rd;
            newEntry.regWrite = id_reg_write;
            newEntry.memRead  = id_mem_read;
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int i = 0; i < N; i++) stage_valid[i] = entries[i].valid;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            entries     <= '0;
            stall_count <= '0;
            flush_count <= '0;
`ifdef PIPE_HAZARD_FWD_EN
            exRs        <= '0;
            exRt        <= '0;
`endif
        end else begin
            entries[0] <= newEntry;
            for (int i = 1; i < N; i++) entries[i] <= entries[i-1];
`ifdef PIPE_HAZARD_FWD_EN
            exRs <= (issue && id_rs_used) ? id_rs : '0;
            exRt <= (issue && id_rt_used) ? id_rt : '0;
`endif
            if (hold_pc && (stall_count != '1)) stall_count <= stall_count + 1'b1;
            if (flush_if_id && (flush_count != '1)) flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow PIPE_HAZARD_FWD_EN when it is defined.
module tb_pipe_hazard_ctrl;

    localparam int STAGES     = 5;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 4;
    localparam int SEL_W      = 3;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                  clock;
    logic                  rst;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  ex_branch_taken;
    logic                  hold_pc;
    logic                  hold_if_id;
    logic                  bubble_id_ex;
    logic                  flush_if_id;
    logic [SEL_W-1:0]      fwd_a;
    logic [SEL_W-1:0]      fwd_b;
    logic [STAGES-3:0]     stage_valid;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    int assertCount = 0;
    int failCount   = 0;

    pipe_hazard_ctrl #(
        .STAGES(STAGES), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W), .SEL_W(SEL_W)
    ) dut (
        .clock(clock), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .hold_pc(hold_pc), .hold_if_id(hold_if_id),
        .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stage_valid(stage_valid), .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsUsed,
                         input logic [4:0] rt, input logic rtUsed, input logic [4:0] rd,
                         input logic regWrite, input logic memRead);
        id_valid     = v;
        id_rs        = rs;
        id_rs_used   = rsUsed;
        id_rt        = rt;
        id_rt_used   = rtUsed;
        id_rd        = rd;
        id_reg_write = regWrite;
        id_mem_read  = memRead;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        ex_branch_taken = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset held with a taken branch and a hazard-looking ID instruction.
        rst = 1'b0;
        ex_branch_taken = 1'b1;
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
        check("rstHoldPc", hold_pc, 0);
        check("rstHoldIfId", hold_if_id, 0);
        check("rstBubble", bubble_id_ex, 0);
        check("rstFlush", flush_if_id, 0);
        check("rstFwdA", fwd_a, 0);
        check("rstFwdB", fwd_b, 0);
        check("rstStallCnt", stall_count, 0);
        check("rstFlushCnt", flush_count, 0);
        check("rstStageValid", stage_valid, 0);
        tick();
        tick();
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        idle();
        check("relHoldPc", hold_pc, 0);
        check("relFlush", flush_if_id, 0);
        check("relStageValid", stage_valid, 0);

`ifdef PIPE_HAZARD_FWD_EN
        // ALU producer forwarded from stage 3.
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        check("aluIssueHold", hold_pc, 0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        check("aluUseHold", hold_pc, 0);
        check("aluUseFwdAPre", fwd_a, 0);
        tick();
        idle();
        check("aluFwdA", fwd_a, 1);
        check("aluFwdB", fwd_b, 0);
        check("aluStallCnt", stall_count, 0);
        tick();
        check("bubbleFwdA", fwd_a, 0);
        // Two producers of r7: the younger one must be selected.
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        check("youngHold", hold_pc, 0);
        tick();
        idle();
        check("youngFwdB", fwd_b, 1);
        check("youngFwdA", fwd_a, 0);
        tick();
        // Producer two stages ahead.
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        tick();
        idle();
        check("far FwdA", fwd_a, 2);
        check("farFwdB", fwd_b, 0);
        tick();
        tick();
        tick();
        // Load-use: one stall cycle, then forward from stage 4.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        check("lwIssueHold", hold_pc, 0);
        tick();
        drive(1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        check("luHoldPc", hold_pc, 1);
        check("luHoldIfId", hold_if_id, 1);
        check("luBubble", bubble_id_ex, 1);
        check("luFlush", flush_if_id, 0);
        tick();
        check("luSecondHold", hold_pc, 0);
        check("luStallCnt", stall_count, 1);
        tick();
        idle();
        check("luFwdA", fwd_a, 2);
        check("luStallCntAfter", stall_count, 1);
`else
        // Without forwarding an ALU producer stalls its reader for two cycles.
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        check("aluIssueHold", hold_pc, 0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        check("nfHold1", hold_pc, 1);
        check("nfBubble1", bubble_id_ex, 1);
        check("nfFwdA1", fwd_a, 0);
        tick();
        check("nfHold2", hold_pc, 1);
        check("nfFwdA2", fwd_a, 0);
        check("nfStallCnt1", stall_count, 1);
        tick();
        check("nfHold3", hold_pc, 0);
        check("nfStallCnt2", stall_count, 2);
        check("nfStageValidWb", stage_valid, 3'b100);
        tick();
        idle();
        check("nfStageValidIssued", stage_valid, 3'b001);
        check("nfFwdA3", fwd_a, 0);
`endif

        // Write to r0 then read r0.
        doReset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd20, 1'b1, 1'b0);
        check("r0Hold", hold_pc, 0);
        tick();
        idle();
        check("r0FwdA", fwd_a, 0);
        check("r0FwdB", fwd_b, 0);
        check("r0StallCnt", stall_count, 0);

        // An invalid ID slot never stalls.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        drive(1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0);
        check("invalidHold", hold_pc, 0);
        check("invalidBubble", bubble_id_ex, 0);
        tick();

        // Unused sources are ignored; a load one stage ahead only blocks without forwarding.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd11, 1'b0, 5'd11, 1'b0, 5'd12, 1'b1, 1'b0);
        check("unusedSrcHold", hold_pc, 0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 5'd13, 1'b1, 1'b0);
        check("loadAtMemHold", hold_pc, FWD ? 0 : 1);

        // Load-use stall cancelled by a taken branch, then flush counter saturation.
        doReset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 1'b0);
        check("rtLuHold", hold_pc, 1);
        check("rtLuBubble", bubble_id_ex, 1);
        ex_branch_taken = 1'b1;
        #1;
        check("brFlush", flush_if_id, 1);
        check("brHoldPc", hold_pc, 0);
        check("brHoldIfId", hold_if_id, 0);
        check("brBubble", bubble_id_ex, 1);
        tick();
        check("brStallCnt", stall_count, 0);
        check("brFlushCnt", flush_count, 1);
        check("brStageValid", stage_valid, 3'b010);
        for (int k = 0; k < 13; k++) tick();
        check("flushCnt14", flush_count, 14);
        for (int k = 0; k < 7; k++) tick();
        check("flushCntSat", flush_count, 15);
        ex_branch_taken = 1'b0;

        // Repeated load-use pairs drive the stall counter to saturation.
        doReset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd13, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0);
            tick();
            tick();
        end
        check("stallCnt10", stall_count, FWD ? 10 : 15);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd13, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0);
            tick();
            tick();
        end
        check("stallCntSat", stall_count, 15);

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd13, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0);
        check("midHoldBefore", hold_pc, 1);
        #1;
        rst = 1'b0;
        #1;
        check("midHoldPc", hold_pc, 0);
        check("midHoldIfId", hold_if_id, 0);
        check("midBubble", bubble_id_ex, 0);
        check("midFlush", flush_if_id, 0);
        check("midStallCnt", stall_count, 0);
        check("midFlushCnt", flush_count, 0);
        check("midStageValid", stage_valid, 0);
        check("midFwdA", fwd_a, 0);
        tick();
        rst = 1'b1;
        #2;
        check("postRstHold", hold_pc, 0);
        check("postRstStageValid", stage_valid, 0);
        tick();
        idle();
        check("postRstIssued", stage_valid, 3'b001);
        check("postRstStallCnt", stall_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter STAGES, default 5, total pipeline depth (IF=0, ID=1, EX=2, WB=STAGES-1); legal range 4..8.
REQ-002 Parameter REG_ADDR_W, default 5, register-address width.
REQ-003 Parameter CNT_W, default 16, width of each event counter.
REQ-004 Parameter SEL_W, default 3, forwarding-select width; SEL_W SHALL be at least clog2(STAGES).
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_rs, id_rt  in  REG_ADDR_W each  source registers decoded in ID.
REQ-009 id_rs_used, id_rt_used  in  1 each  the source is actually read.
REQ-010 id_rd  in  REG_ADDR_W  destination register decoded in ID.
REQ-011 id_reg_write, id_mem_read  in  1 each  ID instruction writes a register / is a load.
REQ-012 ex_branch_taken  in  1  branch in EX resolved taken.
REQ-013 hold_pc, hold_if_id  out  1 each  freeze PC and IF/ID register.
REQ-014 bubble_id_ex, flush_if_id  out  1 each  load a bubble into ID/EX / invalidate IF/ID.
REQ-015 fwd_a, fwd_b  out  SEL_W each  EX operand source: 0 = ID/EX value, k = result of stage 2+k.
REQ-016 stage_valid  out  STAGES-2  valid bits of stages EX..WB, bit 0 = EX.
REQ-017 stall_count, flush_count  out  CNT_W each  event counters.

Function
REQ-018 Block SHALL hold a tracking shift register of STAGES-2 entries {valid, rd, reg_write, mem_read}, entry 0 = EX.
REQ-019 Every rising edge, entries 0..STAGES-4 SHALL shift to entries 1..STAGES-3; the old WB entry (STAGES-3) is discarded.
REQ-020 Entry 0 SHALL load the ID fields when id_valid=1 and neither stall nor flush is active, else a bubble (valid=0).
REQ-021 Producer match: entry valid, reg_write=1, rd equal to source, rd non-zero; register 0 SHALL never match.
REQ-022 fwd_a/fwd_b SHALL be combinational from entries 1..STAGES-3 vs the EX sources tracked in an internal register, selecting the youngest matching entry (smallest index); no match -> 0.
REQ-023 Load-use stall: a used ID source matches entry 0 with mem_read=1 -> hold_pc=1, hold_if_id=1, bubble_id_ex=1 for that cycle.
REQ-024 A load-use stall SHALL last exactly one cycle for STAGES=5; for larger STAGES it SHALL persist until the load reaches stage STAGES-2.
REQ-025 ex_branch_taken=1 SHALL assert flush_if_id=1 and bubble_id_ex=1, force hold_pc=0 and hold_if_id=0, and cancel any stall in the same cycle.
REQ-026 Stall and flush outputs SHALL be combinational from state and inputs; zero added latency.
REQ-027 stall_count SHALL increment by 1 per cycle with hold_pc=1; flush_count by 1 per cycle with flush_if_id=1; both saturate at all-ones.
REQ-028 With id_valid=0, no stall SHALL be raised regardless of source fields.

Reset
REQ-029 rst=0 SHALL asynchronously clear all tracking entries, stage_valid, both counters and the internal EX-source register.
REQ-030 During and right after reset, hold_pc, hold_if_id, bubble_id_ex, flush_if_id SHALL be 0 and fwd_a=fwd_b=0.
REQ-031 Reset asserted mid-stall SHALL end the stall immediately; the next instruction issues normally after release.

Configuration
REQ-032 Macro PIPE_HAZARD_FWD_EN: when defined, forwarding per REQ-022 and load-use stall per REQ-023/024.
REQ-033 When PIPE_HAZARD_FWD_EN is undefined, fwd_a=fwd_b=0 constantly, and any used ID source matching entries 0..STAGES-4 SHALL stall (WB writes before ID read).

Verification
REQ-034 STAGES=5, FWD_EN: add r3 issued, next instr reads r3 -> fwd_a=1, no stall, stall_count=0.
REQ-035 STAGES=5, FWD_EN: lw r4 then add reading r4 -> one cycle hold_pc=1, bubble_id_ex=1, then fwd_a=2, stall_count=1.
REQ-036 Load-use stall and ex_branch_taken in the same cycle -> flush_if_id=1, hold_pc=0, flush_count=1, stall_count unchanged.
REQ-037 Write to r0 followed by read of r0 -> fwd_a=0, no stall.
REQ-038 No FWD_EN, STAGES=5: add r5 then read r5 -> hold_pc=1 for 2 cycles, fwd_a=0 throughout.
REQ-039 rst=0 asserted during a stall -> all outputs 0, counters 0 asynchronously; stage_valid=0 after release.
